// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- OpenMIPS instruction-decode stage with registered ID/EX output.
//
// Decodes logic-immediate (ORI/ANDI/XORI), LUI and SPECIAL logic/shift
// instructions, reads two regfile operands, resolves them through EX/MEM
// forwarding (or stalls when FWD_EN=0), detects load-use hazards and holds
// the result in a valid/ready output register.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o  upstream handshake with the IF/ID register
//   pc_i, inst_i             instruction and its PC
//   reg{1,2}_ren_o/_addr_o   combinational regfile read request
//   reg{1,2}_data_i          regfile read data, same cycle
//   ex_*_i, mem_*_i          write-back info of the EX and MEM instructions
//   flush_i                  drop output register and presented instruction
//   stall_req_o              hazard stall request to the pipeline controller
//   out_valid_o / out_ready_i downstream handshake with EX
//   pc_o .. inst_vld_o       registered decode result
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int DATA_W   = 32,
    parameter int RADDR_W  = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int FWD_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    output logic                reg1_ren_o,
    output logic                reg2_ren_o,
    output logic [RADDR_W-1:0]  reg1_addr_o,
    output logic [RADDR_W-1:0]  reg2_addr_o,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic [RADDR_W-1:0]  ex_waddr_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_load_i,
    input  logic                mem_wreg_i,
    input  logic [RADDR_W-1:0]  mem_waddr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic                flush_i,
    output logic                stall_req_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         pc_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [ALUSEL_W-1:0] alusel_o,
    output logic [DATA_W-1:0]   reg1_data_o,
    output logic [DATA_W-1:0]   reg2_data_o,
    output logic [RADDR_W-1:0]  w_addr_o,
    output logic                wreg_o,
    output logic                inst_vld_o
);

    localparam logic FWD = (FWD_EN != 0);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [ALUOP_W-1:0] ALU_NOP = ALUOP_W'(8'h00);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(8'h03);

    localparam logic [ALUSEL_W-1:0] SEL_NOP   = ALUSEL_W'(3'd0);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'd1);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'd2);

    logic [5:0] op;
    logic [5:0] funct;
    assign op    = inst_i[31:26];
    assign funct = inst_i[5:0];

    // Combinational decode
    logic [ALUOP_W-1:0]  aluop_d;
    logic [ALUSEL_W-1:0] alusel_d;
    logic                wreg_d;
    logic                ivld_d;
    logic                ren1_d, ren2_d;
    logic [RADDR_W-1:0]  raddr1_d, raddr2_d, waddr_d;
    logic [DATA_W-1:0]   imm_d;

    always_comb begin
        aluop_d  = ALU_NOP;
        alusel_d = SEL_NOP;
        wreg_d   = 1'b0;
        ivld_d   = 1'b0;
        ren1_d   = 1'b0;
        ren2_d   = 1'b0;
        raddr1_d = RADDR_W'(inst_i[25:21]);
        raddr2_d = RADDR_W'(inst_i[20:16]);
        waddr_d  = RADDR_W'(inst_i[15:11]);
        imm_d    = '0;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                aluop_d  = (op == OP_ORI) ? ALU_OR : (op == OP_ANDI) ? ALU_AND : ALU_XOR;
                alusel_d = SEL_LOGIC;
                ren1_d   = 1'b1;
                imm_d    = DATA_W'(inst_i[15:0]);
                waddr_d  = RADDR_W'(inst_i[20:16]);
                wreg_d   = 1'b1;
                ivld_d   = 1'b1;
            end
            OP_LUI: begin
                // LUI is executed as $0 | (imm << 16)
                aluop_d  = ALU_OR;
                alusel_d = SEL_LOGIC;
                ren1_d   = 1'b1;
                raddr1_d = '0;
                imm_d    = DATA_W'({inst_i[15:0], 16'h0000});
                waddr_d  = RADDR_W'(inst_i[20:16]);
                wreg_d   = 1'b1;
                ivld_d   = 1'b1;
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        aluop_d  = (funct == FN_AND) ? ALU_AND :
                                   (funct == FN_OR)  ? ALU_OR  :
                                   (funct == FN_XOR) ? ALU_XOR : ALU_NOR;
                        alusel_d = SEL_LOGIC;
                        ren1_d   = 1'b1;
                        ren2_d   = 1'b1;
                        wreg_d   = 1'b1;
                        ivld_d   = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        aluop_d  = (funct == FN_SLL) ? ALU_SLL :
                                   (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                        alusel_d = SEL_SHIFT;
                        ren2_d   = 1'b1;
                        imm_d    = DATA_W'(inst_i[10:6]);
                        wreg_d   = 1'b1;
                        ivld_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Operand resolution: immediate, $0, EX forward, MEM forward, regfile.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic               ren,
        input logic [RADDR_W-1:0] addr,
        input logic [DATA_W-1:0]  rf_data,
        input logic [DATA_W-1:0]  imm
    );
        if (!ren)                                         return imm;
        else if (addr == '0)                              return '0;
        else if (FWD && ex_wreg_i && ex_waddr_i == addr)   return ex_wdata_i;
        else if (FWD && mem_wreg_i && mem_waddr_i == addr) return mem_wdata_i;
        else                                              return rf_data;
    endfunction

    // A load in EX cannot be forwarded yet; without forwarding every
    // outstanding EX/MEM write to a source register must drain first.
    function automatic logic raw_hazard(
        input logic               ren,
        input logic [RADDR_W-1:0] addr
    );
        logic ex_hit, mem_hit;
        ex_hit  = ex_wreg_i  && (ex_waddr_i  == addr);
        mem_hit = mem_wreg_i && (mem_waddr_i == addr);
        return ren && (addr != '0) &&
               ((ex_hit && ex_load_i) || (!FWD && (ex_hit || mem_hit)));
    endfunction

    logic [DATA_W-1:0] op1_d, op2_d;
    logic              hazard;
    logic              in_ready;
    logic              valid_q;

    assign op1_d    = pick_operand(ren1_d, raddr1_d, reg1_data_i, imm_d);
    assign op2_d    = pick_operand(ren2_d, raddr2_d, reg2_data_i, imm_d);
    assign hazard   = in_valid_i && (raw_hazard(ren1_d, raddr1_d) || raw_hazard(ren2_d, raddr2_d));
    assign in_ready = (!valid_q || out_ready_i) && !hazard;

    assign in_ready_o  = in_ready;
    assign stall_req_o = hazard && !flush_i;
    assign reg1_ren_o  = ren1_d;
    assign reg2_ren_o  = ren2_d;
    assign reg1_addr_o = raddr1_d;
    assign reg2_addr_o = raddr2_d;

    // ID/EX output register
    logic [31:0]         pc_q;
    logic [ALUOP_W-1:0]  aluop_q;
    logic [ALUSEL_W-1:0] alusel_q;
    logic [DATA_W-1:0]   op1_q, op2_q;
    logic [RADDR_W-1:0]  waddr_q;
    logic                wreg_q;
    logic                ivld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            aluop_q  <= '0;
            alusel_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            waddr_q  <= '0;
            wreg_q   <= 1'b0;
            ivld_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_valid_i && in_ready) begin
            valid_q  <= 1'b1;
            pc_q     <= pc_i;
            aluop_q  <= aluop_d;
            alusel_q <= alusel_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            waddr_q  <= waddr_d;
            wreg_q   <= wreg_d;
            ivld_q   <= ivld_d;
        end else if (out_ready_i) begin
            // consumed, or a hazard bubble is being inserted
            valid_q <= 1'b0;
        end
    end

    assign out_valid_o = valid_q;
    assign pc_o        = pc_q;
    assign aluop_o     = aluop_q;
    assign alusel_o    = alusel_q;
    assign reg1_data_o = op1_q;
    assign reg2_data_o = op2_q;
    assign w_addr_o    = waddr_q;
    assign wreg_o      = wreg_q;
    assign inst_vld_o  = ivld_q;

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed testbench for id_stage.
// Two instances share all inputs: u_fwd (FWD_EN=1) and u_stl (FWD_EN=0).
// ---------------------------------------------------------------------------
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic [31:0] pc_i, inst_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_load_i, mem_wreg_i;
    logic [4:0]  ex_waddr_i, mem_waddr_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        flush_i, out_ready_i;

    // FWD_EN=1 instance outputs
    logic        in_ready, stall_req, out_valid, r1_ren, r2_ren, wreg, inst_vld;
    logic [4:0]  r1_addr, r2_addr, w_addr;
    logic [31:0] pc_o, r1_data, r2_data;
    logic [7:0]  aluop;
    logic [2:0]  alusel;

    // FWD_EN=0 instance outputs
    logic        s_in_ready, s_stall_req, s_out_valid, s_r1_ren, s_r2_ren, s_wreg, s_inst_vld;
    logic [4:0]  s_r1_addr, s_r2_addr, s_w_addr;
    logic [31:0] s_pc_o, s_r1_data, s_r2_data;
    logic [7:0]  s_aluop;
    logic [2:0]  s_alusel;

    int checks = 0;
    int errors = 0;

    id_stage #(.FWD_EN(1)) u_fwd (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_ren_o(r1_ren), .reg2_ren_o(r2_ren), .reg1_addr_o(r1_addr), .reg2_addr_o(r2_addr),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .stall_req_o(stall_req), .out_valid_o(out_valid), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .aluop_o(aluop), .alusel_o(alusel), .reg1_data_o(r1_data), .reg2_data_o(r2_data),
        .w_addr_o(w_addr), .wreg_o(wreg), .inst_vld_o(inst_vld)
    );

    id_stage #(.FWD_EN(0)) u_stl (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_ren_o(s_r1_ren), .reg2_ren_o(s_r2_ren), .reg1_addr_o(s_r1_addr), .reg2_addr_o(s_r2_addr),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_load_i(ex_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .stall_req_o(s_stall_req), .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .pc_o(s_pc_o), .aluop_o(s_aluop), .alusel_o(s_alusel), .reg1_data_o(s_r1_data), .reg2_data_o(s_r2_data),
        .w_addr_o(s_w_addr), .wreg_o(s_wreg), .inst_vld_o(s_inst_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid_i  = 1'b0;
        pc_i        = 32'h0;
        inst_i      = 32'h0;
        reg1_data_i = 32'h1111_1111;
        reg2_data_i = 32'h2222_2222;
        ex_wreg_i   = 1'b0;
        ex_load_i   = 1'b0;
        ex_waddr_i  = 5'd0;
        ex_wdata_i  = 32'h0;
        mem_wreg_i  = 1'b0;
        mem_waddr_i = 5'd0;
        mem_wdata_i = 32'h0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        checks++; if (aluop !== 8'h00) begin errors++; $display("FAIL reset_aluop: got %0h want 0", aluop); end
        checks++; if (r1_data !== 32'h0) begin errors++; $display("FAIL reset_r1: got %0h want 0", r1_data); end
        checks++; if (w_addr !== 5'd0 || wreg !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL reset_payload: got w_addr=%0h wreg=%0h pc=%0h want 0", w_addr, wreg, pc_o); end
        checks++; if (stall_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_hs: got stall=%0h ready=%0h want 0/1", stall_req, in_ready); end
    endtask

    task automatic test_ori();
        idle_inputs();
        in_valid_i = 1'b1; pc_i = 32'h0000_0100; inst_i = 32'h3401_1234;
        #1;
        checks++; if (r1_ren !== 1'b1 || r2_ren !== 1'b0 || r1_addr !== 5'd0) begin errors++; $display("FAIL ori_ren: got ren1=%0h ren2=%0h a1=%0h want 1/0/0", r1_ren, r2_ren, r1_addr); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ori_valid: got %0h want 1", out_valid); end
        checks++; if (aluop !== 8'h25 || alusel !== 3'd1) begin errors++; $display("FAIL ori_op: got %0h/%0h want 25/1", aluop, alusel); end
        checks++; if (r1_data !== 32'h0 || r2_data !== 32'h0000_1234) begin errors++; $display("FAIL ori_data: got %0h/%0h want 0/1234", r1_data, r2_data); end
        checks++; if (w_addr !== 5'd1 || wreg !== 1'b1 || inst_vld !== 1'b1 || pc_o !== 32'h100) begin errors++; $display("FAIL ori_wb: got w=%0h wreg=%0h vld=%0h pc=%0h want 1/1/1/100", w_addr, wreg, inst_vld, pc_o); end
        tick();
        checks++; if (out_valid !== 1'b0 || aluop !== 8'h25) begin errors++; $display("FAIL ori_drain: got valid=%0h aluop=%0h want 0/25", out_valid, aluop); end
    endtask

    task automatic test_forward();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h0022_1825;   // OR $3,$1,$2
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hAAAA_0000;
        mem_wreg_i = 1'b1; mem_waddr_i = 5'd2; mem_wdata_i = 32'h0000_5555;
        #1;
        checks++; if (in_ready !== 1'b1 || stall_req !== 1'b0) begin errors++; $display("FAIL fwd_hs: got ready=%0h stall=%0h want 1/0", in_ready, stall_req); end
        checks++; if (s_stall_req !== 1'b1 || s_in_ready !== 1'b0) begin errors++; $display("FAIL stl_or_hazard: got stall=%0h ready=%0h want 1/0", s_stall_req, s_in_ready); end
        tick();
        checks++; if (r1_data !== 32'hAAAA_0000 || r2_data !== 32'h0000_5555) begin errors++; $display("FAIL fwd_exmem: got %0h/%0h want aaaa0000/5555", r1_data, r2_data); end
        checks++; if (aluop !== 8'h25 || w_addr !== 5'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL fwd_or: got aluop=%0h w=%0h v=%0h want 25/3/1", aluop, w_addr, out_valid); end
        // EX and MEM both write $1: the younger EX value wins
        mem_waddr_i = 5'd1; mem_wdata_i = 32'h7777_7777;
        tick();
        checks++; if (r1_data !== 32'hAAAA_0000 || r2_data !== 32'h2222_2222) begin errors++; $display("FAIL fwd_prio: got %0h/%0h want aaaa0000/22222222", r1_data, r2_data); end
        in_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; pc_i = 32'h200; inst_i = 32'h3401_1234;   // ORI $1,$0,0x1234
        tick();
        pc_i = 32'h204; inst_i = 32'h0002_2900;                        // SLL $5,$2,4
        #1;
        checks++; if (in_ready !== 1'b1 || r1_ren !== 1'b0 || r2_ren !== 1'b1) begin errors++; $display("FAIL b2b_ready: got ready=%0h ren=%0h%0h want 1/01", in_ready, r1_ren, r2_ren); end
        checks++; if (pc_o !== 32'h200 || r2_data !== 32'h1234) begin errors++; $display("FAIL b2b_first: got pc=%0h r2=%0h want 200/1234", pc_o, r2_data); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid !== 1'b1 || pc_o !== 32'h204 || aluop !== 8'h7C || alusel !== 3'd2) begin errors++; $display("FAIL b2b_sll_op: got v=%0h pc=%0h aluop=%0h sel=%0h want 1/204/7c/2", out_valid, pc_o, aluop, alusel); end
        checks++; if (r1_data !== 32'h4 || r2_data !== 32'h2222_2222 || w_addr !== 5'd5) begin errors++; $display("FAIL b2b_sll_data: got %0h/%0h w=%0h want 4/22222222/5", r1_data, r2_data, w_addr); end
        tick();
    endtask

    task automatic test_load_use();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h3401_1234;
        tick();
        // load to $1 in EX, ORI $2,$1,1 presented while output register is full
        inst_i = 32'h3422_0001; pc_i = 32'h300;
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hDEAD_DEAD;
        #1;
        checks++; if (stall_req !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got stall=%0h ready=%0h want 1/0", stall_req, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0h want 0", out_valid); end
        ex_wreg_i = 1'b0; ex_load_i = 1'b0; ex_waddr_i = 5'd0;
        mem_wreg_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h1234_0000;
        #1;
        checks++; if (stall_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got stall=%0h ready=%0h want 0/1", stall_req, in_ready); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid !== 1'b1 || r1_data !== 32'h1234_0000 || r2_data !== 32'h1 || w_addr !== 5'd2 || pc_o !== 32'h300) begin errors++; $display("FAIL lu_accept: got v=%0h r1=%0h r2=%0h w=%0h pc=%0h want 1/12340000/1/2/300", out_valid, r1_data, r2_data, w_addr, pc_o); end
        tick();
    endtask

    task automatic test_no_forward();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h3422_0001;   // ORI $2,$1,1
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd1; ex_wdata_i = 32'h0000_AAAA;
        #1;
        checks++; if (s_stall_req !== 1'b1 || s_in_ready !== 1'b0) begin errors++; $display("FAIL nf_ex_stall: got stall=%0h ready=%0h want 1/0", s_stall_req, s_in_ready); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL nf_ex_bubble: got %0h want 0", s_out_valid); end
        ex_wreg_i = 1'b0; ex_waddr_i = 5'd0;
        mem_wreg_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h0000_BBBB;
        #1;
        checks++; if (s_stall_req !== 1'b1 || s_in_ready !== 1'b0) begin errors++; $display("FAIL nf_mem_stall: got stall=%0h ready=%0h want 1/0", s_stall_req, s_in_ready); end
        tick();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL nf_mem_bubble: got %0h want 0", s_out_valid); end
        // producer has written back; an unrelated EX write must not be forwarded
        mem_wreg_i = 1'b0; mem_waddr_i = 5'd0;
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd7; ex_wdata_i = 32'hFFFF_FFFF;
        reg1_data_i = 32'h0000_BBBB;
        #1;
        checks++; if (s_stall_req !== 1'b0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL nf_release: got stall=%0h ready=%0h want 0/1", s_stall_req, s_in_ready); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (s_out_valid !== 1'b1 || s_r1_data !== 32'h0000_BBBB || s_r2_data !== 32'h1) begin errors++; $display("FAIL nf_accept: got v=%0h r1=%0h r2=%0h want 1/bbbb/1", s_out_valid, s_r1_data, s_r2_data); end
        tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h3C04_BEEF; pc_i = 32'h400;   // LUI $4,0xBEEF
        #1;
        checks++; if (r1_ren !== 1'b1 || r1_addr !== 5'd0) begin errors++; $display("FAIL lui_addr: got ren=%0h a1=%0h want 1/0", r1_ren, r1_addr); end
        tick();
        out_ready_i = 1'b0;
        inst_i = 32'h3401_1234; pc_i = 32'h404;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %0h want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || r2_data !== 32'hBEEF_0000 || r1_data !== 32'h0 || w_addr !== 5'd4 || pc_o !== 32'h400) begin errors++; $display("FAIL bp_hold%0d: got v=%0h r1=%0h r2=%0h w=%0h pc=%0h want 1/0/beef0000/4/400", i, out_valid, r1_data, r2_data, w_addr, pc_o); end
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %0h want 1", in_ready); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid !== 1'b1 || pc_o !== 32'h404 || r2_data !== 32'h1234) begin errors++; $display("FAIL bp_next: got v=%0h pc=%0h r2=%0h want 1/404/1234", out_valid, pc_o, r2_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0h want 0", out_valid); end
    endtask

    task automatic test_flush_invalid();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h3401_1234; pc_i = 32'h500;
        tick();
        // XORI $6,$3,0xFF with a load-use on $3, flushed in the same cycle
        inst_i = 32'h3866_00FF; pc_i = 32'h504; flush_i = 1'b1;
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd3;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h want 0", stall_req); end
        tick();
        checks++; if (out_valid !== 1'b0 || aluop !== 8'h25 || pc_o !== 32'h500) begin errors++; $display("FAIL flush_drop: got v=%0h aluop=%0h pc=%0h want 0/25/500", out_valid, aluop, pc_o); end
        flush_i = 1'b0; ex_wreg_i = 1'b0; ex_load_i = 1'b0; ex_waddr_i = 5'd0;
        inst_i = 32'hFC00_0000; pc_i = 32'h508;
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid !== 1'b1 || inst_vld !== 1'b0 || wreg !== 1'b0 || pc_o !== 32'h508) begin errors++; $display("FAIL inv_flags: got v=%0h vld=%0h wreg=%0h pc=%0h want 1/0/0/508", out_valid, inst_vld, wreg, pc_o); end
        checks++; if (aluop !== 8'h00 || alusel !== 3'd0 || r1_data !== 32'h0 || r2_data !== 32'h0) begin errors++; $display("FAIL inv_payload: got aluop=%0h sel=%0h r1=%0h r2=%0h want 0", aluop, alusel, r1_data, r2_data); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        do_reset();
        in_valid_i = 1'b1; inst_i = 32'h3401_1234;
        tick();
        inst_i = 32'h3422_0001;
        ex_wreg_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd1;
        out_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || stall_req !== 1'b1) begin errors++; $display("FAIL rst_stall: got v=%0h stall=%0h want 0/1", out_valid, stall_req); end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_ori();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_no_forward();
        test_backpressure();
        test_flush_invalid();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
